// File: rtl/imem_stream_loader_pkg.sv
// imem_loader_pkg: types and constants shared by the instruction-memory
// stream loader, its interface users and the byte packer.
//   state_e        loader FSM states (ERR is only reachable when the
//                  IMEM_LOADER_CHECKSUM_EN build option is defined)
//   BYTES_PER_WORD bytes packed into one instruction word
//   ADDR_STRIDE    byte-address increment between consecutive words
//   insert_lane()  returns a word with one byte lane replaced
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_STRIDE    = 4;

    function automatic logic [31:0] insert_lane(input logic [31:0] w,
                                                input logic [1:0]  k,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (k)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_stream_loader_if.sv
// imem_stream_loader_if: byte stream in, instruction-memory write port out.
//   s_valid/s_data/s_ready     byte stream handshake (source -> loader)
//   addr_ext/wen_ext/wdata_ext external instruction-memory write port
// Modports:
//   slave  - the loader: consumes the stream, drives the memory port
//   master - the environment: sources the stream, observes the memory port
interface imem_stream_loader_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic [31:0] wdata_ext;

    modport slave (
        input  s_valid, s_data,
        output s_ready, addr_ext, wen_ext, wdata_ext
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, addr_ext, wen_ext, wdata_ext
    );
endinterface

// File: rtl/imem_stream_loader_byte_packer.sv
// byte_packer: collects bytes little-endian into a 32-bit word.
//   clk, arst_n  clock / async active-low reset
//   flush        clears the byte counter and lanes (dominates byte_en)
//   byte_en      a byte is accepted this cycle
//   byte_data    the accepted byte
//   word_valid   high in the cycle the 4th byte is accepted
//   word         packed word including the byte accepted this cycle
module byte_packer (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        flush,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);
    import imem_loader_pkg::*;

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] lanes_q, lanes_d;

    always_comb begin
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        if (flush) begin
            cnt_d   = 2'd0;
            lanes_d = 32'd0;
        end else if (byte_en) begin
            lanes_d = insert_lane(lanes_q, cnt_q, byte_data);
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // The word is presented combinationally so the top can capture it on
    // the same edge that accepts the final byte.
    assign word       = insert_lane(lanes_q, cnt_q, byte_data);
    assign word_valid = byte_en && !flush && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q   <= 2'd0;
            lanes_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
        end
    end
endmodule

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: boot loader that streams bytes into instruction memory
// and then enables the CPU.
//   clk, arst_n   clock / async active-low reset
//   start         pulse; begins a load (IDLE only), num_words sampled here
//   num_words     words to load, 0 .. 2**ADDR_W
//   stop          return to IDLE from LOAD/WRITE (abort, sets err) or RUN
//   bus           imem_stream_loader_if.slave: byte stream + memory port
//   cpu_enable    CPU enable, registered, high only in RUN
//   words_loaded  words written in the current or last load
//   busy          high while accepting bytes
//   err           sticky error, cleared by the next accepted start
// Build option IMEM_LOADER_CHECKSUM_EN: a trailing checksum word (32-bit
// wrap-around sum of the data words) is received after the data and
// compared; a mismatch parks the FSM in ERR until stop or reset.
//
// state | meaning
// IDLE  | waiting for start, stream not ready
// LOAD  | accepting bytes of the current word (or checksum word)
// WRITE | one-cycle instruction-memory write of the packed word
// RUN   | load complete, CPU enabled
// ERR   | checksum mismatch, CPU held disabled
module imem_stream_loader #(
    parameter int          ADDR_W    = 9,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                start,
    input  logic [ADDR_W:0]     num_words,
    input  logic                stop,
    imem_stream_loader_if.slave bus,
    output logic                cpu_enable,
    output logic [ADDR_W:0]     words_loaded,
    output logic                busy,
    output logic                err
);
    import imem_loader_pkg::*;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [ADDR_W:0] num_q, num_d;
    logic [ADDR_W:0] wl_q, wl_d;
    logic [ADDR_W:0] wl_next;
    logic            err_q, err_d;
    logic            cpu_en_q, cpu_en_d;
    logic [63:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]     sum_q, sum_d;
    logic            chk_q, chk_d;
`endif

    logic            in_load;
    logic            byte_en;
    logic            flush;
    logic            word_valid;
    logic [31:0]     packed_word;

    assign in_load = (state_q == LOAD);
    assign byte_en = in_load && bus.s_valid && !stop;
    // Partial bytes never survive an abort; IDLE also keeps the packer clean.
    assign flush   = (state_q == IDLE) || (stop && (in_load || state_q == WRITE));
    assign wl_next = wl_q + ONE;

    byte_packer u_packer (
        .clk        (clk),
        .arst_n     (arst_n),
        .flush      (flush),
        .byte_en    (byte_en),
        .byte_data  (bus.s_data),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        wl_d    = wl_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        chk_d   = chk_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    if (num_words > CAPACITY) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        wl_d    = '0;
                        num_d   = num_words;
                        state_d = (num_words == '0) ? RUN : LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d   = 32'd0;
                        chk_d   = 1'b0;
`endif
                    end
                end
            end
            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (word_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (chk_q) begin
                        if (packed_word == sum_q) begin
                            state_d = RUN;
                        end else begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = WRITE;
                        addr_d  = BASE_ADDR + 64'(ADDR_STRIDE) * 64'(wl_q);
                        wdata_d = packed_word;
                    end
`else
                    state_d = WRITE;
                    addr_d  = BASE_ADDR + 64'(ADDR_STRIDE) * 64'(wl_q);
                    wdata_d = packed_word;
`endif
                end
            end
            WRITE: begin
                // The write strobe of this cycle always completes, so the
                // word counts as loaded even if stop arrives now.
                wl_d = wl_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d = sum_q + wdata_q;
`endif
                if (stop) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (wl_next == num_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = LOAD;
                    chk_d   = 1'b1;
`else
                    state_d = RUN;
`endif
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (stop) state_d = IDLE;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ERR: begin
                if (stop) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Enable rises one cycle after RUN is entered and drops with the exit.
    assign cpu_en_d = (state_q == RUN) && (state_d == RUN);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            num_q    <= '0;
            wl_q     <= '0;
            err_q    <= 1'b0;
            cpu_en_q <= 1'b0;
            addr_q   <= 64'd0;
            wdata_q  <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= 32'd0;
            chk_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            wl_q     <= wl_d;
            err_q    <= err_d;
            cpu_en_q <= cpu_en_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
            chk_q    <= chk_d;
`endif
        end
    end

    assign bus.s_ready   = in_load;
    assign bus.wen_ext   = (state_q == WRITE);
    assign bus.addr_ext  = addr_q;
    assign bus.wdata_ext = wdata_q;
    assign cpu_enable    = cpu_en_q;
    assign words_loaded  = wl_q;
    assign busy          = in_load;
    assign err           = err_q;
endmodule
